// File: rtl/instruction_memory_if.sv
// rtl/instruction_memory_if.sv - fetch and program-load bus for instruction_memory
interface instruction_memory_if #(
    parameter int DEPTH_LOG2 = 8
) ();
    logic                  fetch_req;
    logic [31:0]           address_in;
    logic [31:0]           instr_out;
    logic                  instr_valid;
    logic                  addr_fault;
    logic                  load_en;
    logic [31:0]           load_data;
    logic                  load_valid;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic                  load_overflow;
    logic [DEPTH_LOG2:0]   loaded_words;

    // Requester side: CPU fetch unit plus boot/program source
    modport master (
        output fetch_req, address_in, load_en, load_data, load_valid, load_last,
        input  instr_out, instr_valid, addr_fault, load_ready, load_done,
               load_overflow, loaded_words
    );

    // Memory side
    modport slave (
        input  fetch_req, address_in, load_en, load_data, load_valid, load_last,
        output instr_out, instr_valid, addr_fault, load_ready, load_done,
               load_overflow, loaded_words
    );
endinterface

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word instruction store with streaming loader and fetch fault detection
module instruction_memory #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_memory_if.slave  bus
);
    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [32:0]       MEM_BYTES = 33'd4 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] ONE_W   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [31:0]             r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0]   r_ptr;
    logic [DEPTH_LOG2:0]     r_loaded_words;
    logic                    r_load_done;
    logic                    r_load_overflow;
    logic [31:0]             r_instr_out;
    logic                    r_instr_valid;
    logic                    r_addr_fault;

    logic                    w_load_fire;
    logic                    w_load_exit;
    logic                    w_load_start;
    logic                    w_fetch_fire;
    logic [31:0]             w_offset;
    logic [DEPTH_LOG2-1:0]   w_index;
    logic                    w_fault;
    logic                    w_unloaded;

    // Address decode: offset from the base, word index, fault and unloaded-word detection
    assign w_offset   = bus.address_in - BASE_ADDR;
    assign w_index    = w_offset[DEPTH_LOG2+1:2];
    // BASE_ADDR is word aligned, so the low offset bits equal the low address bits
    assign w_fault    = ((bus.address_in[1:0] | w_offset[1:0]) != 2'b00)
                      || (bus.address_in < BASE_ADDR)
                      || ({1'b0, w_offset} >= MEM_BYTES);
    assign w_unloaded = ({1'b0, w_index} >= r_loaded_words);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and per-cycle strobes; a load request in RUN wins over a fetch
    always_comb begin
        w_state_next = r_state;
        w_load_fire  = 1'b0;
        w_load_exit  = 1'b0;
        w_fetch_fire = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_en) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_load_fire = bus.load_valid;
                if (bus.load_valid && (bus.load_last || (&r_ptr))) begin
                    w_load_exit  = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (bus.load_en) begin
                    w_state_next = LOAD;
                end else begin
                    w_fetch_fire = bus.fetch_req;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_load_start = (r_state != LOAD) && (w_state_next == LOAD);

    // Storage array; deliberately not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_ptr] <= bus.load_data;
        end
    end

    // Loader bookkeeping: write pointer, word count, completion pulse, overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr           <= '0;
            r_loaded_words  <= '0;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
        end else begin
            r_load_done <= w_load_exit;
            if (w_load_start) begin
                r_ptr           <= '0;
                r_load_overflow <= 1'b0;
            end
            if (w_load_fire) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_load_exit) begin
                r_loaded_words <= {1'b0, r_ptr} + ONE_W;
                if (!bus.load_last) begin
                    r_load_overflow <= 1'b1;
                end
            end
        end
    end

    // Fetch response register; instr_out holds its value between requests
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr_out   <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_fire;
            r_addr_fault  <= w_fetch_fire && w_fault;
            if (w_fetch_fire) begin
                if (w_fault || w_unloaded) begin
                    r_instr_out <= NOP_WORD;
                end else begin
                    r_instr_out <= r_mem[w_index];
                end
            end
        end
    end

    assign bus.instr_out     = r_instr_out;
    assign bus.instr_valid   = r_instr_valid;
    assign bus.addr_fault    = r_addr_fault;
    assign bus.load_ready    = (r_state == LOAD);
    assign bus.load_done     = r_load_done;
    assign bus.load_overflow = r_load_overflow;
    assign bus.loaded_words  = r_loaded_words;
endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - self-checking bench for instruction_memory
module tb_instruction_memory;
    localparam int          DL2    = 8;
    localparam int          DEPTH  = 1 << DL2;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0040_0000;

    logic clk;
    logic reset;

    instruction_memory_if #(.DEPTH_LOG2(DL2)) bus ();
    instruction_memory_if #(.DEPTH_LOG2(DL2)) bus_b ();

    instruction_memory #(.DEPTH_LOG2(DL2), .BASE_ADDR(32'h0), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instruction_memory #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE_B), .NOP_WORD(NOP)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] mm [DEPTH];
    int          model_loaded = 0;
    logic [31:0] ld_words [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } fvec_t;

    fvec_t tv [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Expected {fault, data} for a fetch from the base-0 instance
    function automatic logic [32:0] model_fetch(input logic [31:0] a);
        longint off;
        longint idx;
        off = longint'(a);
        if ((off % 4) != 0 || off >= 4 * DEPTH) return {1'b1, NOP};
        idx = off / 4;
        if (idx >= model_loaded) return {1'b0, NOP};
        return {1'b0, mm[idx]};
    endfunction

    task automatic do_load(input int n, input bit use_last, input bit gaps);
        int i;
        int guard;
        bit v;
        bus.load_en = 1'b1;
        tick();
        bus.load_en = 1'b0;
        check("load_ready_in_load", {63'b0, bus.load_ready}, 64'd1);
        check("loaded_words_held", {55'b0, bus.loaded_words}, 64'(model_loaded));
        check("overflow_cleared", {63'b0, bus.load_overflow}, 64'd0);
        i = 0;
        guard = 0;
        while (i < n && guard < 4000) begin
            guard++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.load_valid = v;
            bus.load_data  = ld_words[i];
            bus.load_last  = use_last && (i == n - 1);
            tick();
            if (v) begin
                mm[i] = ld_words[i];
                i++;
            end
        end
        if (i < n) check("load_timeout", 64'(i), 64'(n));
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        model_loaded = n;
        check("load_done_pulse", {63'b0, bus.load_done}, 64'd1);
        check("loaded_words", {55'b0, bus.loaded_words}, 64'(n));
        check("load_overflow", {63'b0, bus.load_overflow}, {63'b0, !use_last});
        check("load_ready_after", {63'b0, bus.load_ready}, 64'd0);
        tick();
        check("load_done_one_cycle", {63'b0, bus.load_done}, 64'd0);
    endtask

    task automatic fetch1(input string nm, input logic [31:0] a, input logic [31:0] d, input logic f);
        bus.fetch_req  = 1'b1;
        bus.address_in = a;
        tick();
        bus.fetch_req  = 1'b0;
        check({nm, "_valid"}, {63'b0, bus.instr_valid}, 64'd1);
        check({nm, "_data"}, {32'b0, bus.instr_out}, {32'b0, d});
        check({nm, "_fault"}, {63'b0, bus.addr_fault}, {63'b0, f});
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] last_data;
        logic [31:0] a;
        bit          r;

        reset = 1'b0;
        bus.fetch_req = 0; bus.address_in = 0; bus.load_en = 0;
        bus.load_data = 0; bus.load_valid = 0; bus.load_last = 0;
        bus_b.fetch_req = 0; bus_b.address_in = 0; bus_b.load_en = 0;
        bus_b.load_data = 0; bus_b.load_valid = 0; bus_b.load_last = 0;
        repeat (3) tick();

        // Reset state
        check("rst_instr_out", {32'b0, bus.instr_out}, {32'b0, NOP});
        check("rst_instr_valid", {63'b0, bus.instr_valid}, 64'd0);
        check("rst_addr_fault", {63'b0, bus.addr_fault}, 64'd0);
        check("rst_load_ready", {63'b0, bus.load_ready}, 64'd0);
        check("rst_load_done", {63'b0, bus.load_done}, 64'd0);
        check("rst_load_overflow", {63'b0, bus.load_overflow}, 64'd0);
        check("rst_loaded_words", {55'b0, bus.loaded_words}, 64'd0);

        // Fetch in IDLE is ignored
        reset = 1'b1;
        bus.fetch_req = 1'b1;
        bus.address_in = 32'h0;
        tick();
        bus.fetch_req = 1'b0;
        check("idle_fetch_ignored", {63'b0, bus.instr_valid}, 64'd0);

        // Four-word program with load_last
        ld_words[0] = 32'h2008_0005; ld_words[1] = 32'h2009_0003;
        ld_words[2] = 32'h0109_5020; ld_words[3] = 32'h0800_0000;
        do_load(4, 1'b1, 1'b0);

        // Back-to-back fetch vectors
        tv[0] = '{32'h0000_0000, 32'h2008_0005, 1'b0};
        tv[1] = '{32'h0000_0004, 32'h2009_0003, 1'b0};
        tv[2] = '{32'h0000_0008, 32'h0109_5020, 1'b0};
        tv[3] = '{32'h0000_000C, 32'h0800_0000, 1'b0};
        tv[4] = '{32'h0000_0010, NOP,           1'b0};
        tv[5] = '{32'h0000_0002, NOP,           1'b1};
        tv[6] = '{32'h0000_0400, NOP,           1'b1};
        tv[7] = '{32'hFFFF_FFFC, NOP,           1'b1};
        tv[8] = '{32'h0000_0008, 32'h0109_5020, 1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.fetch_req  = 1'b1;
            bus.address_in = tv[i].addr;
            tick();
            check($sformatf("vec%0d_valid", i), {63'b0, bus.instr_valid}, 64'd1);
            check($sformatf("vec%0d_data", i), {32'b0, bus.instr_out}, {32'b0, tv[i].data});
            check($sformatf("vec%0d_fault", i), {63'b0, bus.addr_fault}, {63'b0, tv[i].fault});
        end
        bus.fetch_req = 1'b0;
        tick();
        check("idle_cycle_valid", {63'b0, bus.instr_valid}, 64'd0);
        check("idle_cycle_hold", {32'b0, bus.instr_out}, {32'b0, tv[8].data});

        // Full-memory load without load_last, with random valid gaps
        for (int i = 0; i < DEPTH; i++) ld_words[i] = $urandom;
        do_load(DEPTH, 1'b0, 1'b1);
        fetch1("last_word", 32'h0000_03FC, ld_words[DEPTH-1], 1'b0);

        // Randomized fetches against the model
        last_data = bus.instr_out;
        for (int c = 0; c < 300; c++) begin
            r = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
                6:                a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                7:                a = 32'h400 + 32'($urandom_range(0, 4096));
                8:                a = $urandom;
                default:          a = 32'h3FC + 32'($urandom_range(0, 1)) * 4;
            endcase
            bus.fetch_req  = r;
            bus.address_in = a;
            tick();
            check("rnd_valid", {63'b0, bus.instr_valid}, {63'b0, r});
            if (r) begin
                e = model_fetch(a);
                check("rnd_data", {32'b0, bus.instr_out}, {32'b0, e[31:0]});
                check("rnd_fault", {63'b0, bus.addr_fault}, {63'b0, e[32]});
                last_data = e[31:0];
            end else begin
                check("rnd_hold", {32'b0, bus.instr_out}, {32'b0, last_data});
            end
        end

        // Simultaneous load_en and fetch_req: load wins
        bus.fetch_req  = 1'b1;
        bus.load_en    = 1'b1;
        bus.address_in = 32'h0;
        tick();
        bus.fetch_req = 1'b0;
        bus.load_en   = 1'b0;
        check("collide_no_valid", {63'b0, bus.instr_valid}, 64'd0);
        check("collide_in_load", {63'b0, bus.load_ready}, 64'd1);
        check("collide_ovf_clr", {63'b0, bus.load_overflow}, 64'd0);
        check("collide_words_kept", {55'b0, bus.loaded_words}, 64'(DEPTH));

        // Reset after two words of a load
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hA5A5_0000 + 32'(i);
            tick();
            mm[i] = 32'hA5A5_0000 + 32'(i);
        end
        bus.load_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_loaded = 0;
        check("midrst_loaded_words", {55'b0, bus.loaded_words}, 64'd0);
        check("midrst_idle", {63'b0, bus.load_ready}, 64'd0);
        ld_words[0] = 32'h1234_5678;
        do_load(1, 1'b1, 1'b0);
        fetch1("after_rst_unloaded", 32'h4, NOP, 1'b0);
        fetch1("after_rst_word0", 32'h0, 32'h1234_5678, 1'b0);

        // Non-zero base address instance
        bus_b.load_en = 1'b1;
        tick();
        bus_b.load_en    = 1'b0;
        bus_b.load_valid = 1'b1;
        bus_b.load_last  = 1'b1;
        bus_b.load_data  = 32'hDEAD_BEEF;
        tick();
        bus_b.load_valid = 1'b0;
        bus_b.load_last  = 1'b0;
        check("b_load_done", {63'b0, bus_b.load_done}, 64'd1);
        bus_b.fetch_req = 1'b1;
        bus_b.address_in = 32'h0;
        tick();
        check("b_below_base_fault", {63'b0, bus_b.addr_fault}, 64'd1);
        check("b_below_base_data", {32'b0, bus_b.instr_out}, {32'b0, NOP});
        bus_b.address_in = BASE_B;
        tick();
        check("b_base_fault", {63'b0, bus_b.addr_fault}, 64'd0);
        check("b_base_data", {32'b0, bus_b.instr_out}, 64'h0000_0000_DEAD_BEEF);
        bus_b.address_in = BASE_B + 32'h400;
        tick();
        check("b_top_fault", {63'b0, bus_b.addr_fault}, 64'd1);
        bus_b.address_in = BASE_B + 32'h4;
        tick();
        bus_b.fetch_req = 1'b0;
        check("b_unloaded_fault", {63'b0, bus_b.addr_fault}, 64'd0);
        check("b_unloaded_data", {32'b0, bus_b.instr_out}, {32'b0, NOP});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
